// File: rtl/pic_int_sequencer.sv
// 8259 PIC sequencer: priority resolution, two-pulse INTA handshake, in-service tracking, vector drive.
// Define PIC_ROTATE_EN for automatic priority rotation on non-specific EOI and AEOI completion.
module pic_int_sequencer #(
  parameter int unsigned NUM_IR     = 8,
  parameter int unsigned VEC_BASE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IR-1:0]     irr,
  input  logic [NUM_IR-1:0]     imr,
  input  logic                  inta_n,
  input  logic                  eoi_cmd,
  input  logic                  eoi_specific,
  input  logic [2:0]            eoi_level,
  input  logic                  auto_eoi,
  input  logic [VEC_BASE_W-1:0] vec_base,
  output logic                  int_out,
  output logic [NUM_IR-1:0]     isr,
  output logic [NUM_IR-1:0]     irr_clear,
  output logic [VEC_BASE_W+2:0] vector_out,
  output logic                  vector_oe
);

`ifdef PIC_ROTATE_EN
  localparam bit ROTATE = 1'b1;
`else
  localparam bit ROTATE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_e;

  state_e                  state_q, state_d;
  logic                    inta_q;
  logic [2:0]              ptr_q, ptr_d;
  logic [2:0]              level_q, level_d;
  logic                    spur_q, spur_d;
  logic [NUM_IR-1:0]       isr_q, isr_d;
  logic                    int_out_q, int_out_d;
  logic [NUM_IR-1:0]       irr_clear_q, irr_clear_d;
  logic [VEC_BASE_W+2:0]   vec_q, vec_d;
  logic                    vec_oe_q, vec_oe_d;

  logic                    inta_fall, inta_rise;
  logic                    win_v, top_v, qual;
  logic [2:0]              win_lvl, top_lvl;

  // Scan starts just after the rotation pointer; returns {found, level}.
  function automatic logic [3:0] pick(input logic [NUM_IR-1:0] v, input logic [2:0] ptr);
    logic [2:0] lvl;
    pick = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      lvl = ptr + 3'(i + 1);
      if (!pick[3] && v[lvl]) pick = {1'b1, lvl};
    end
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] ptr);
    rank = lvl - ptr - 3'd1;
  endfunction

  assign inta_fall          = inta_q & ~inta_n;
  assign inta_rise          = ~inta_q & inta_n;
  assign {win_v, win_lvl}   = pick(irr & ~imr, ptr_q);
  assign {top_v, top_lvl}   = pick(isr_q, ptr_q);
  assign qual               = win_v & (~top_v | (rank(win_lvl, ptr_q) < rank(top_lvl, ptr_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inta_q      <= 1'b1;
      ptr_q       <= 3'd7;
      level_q     <= 3'd7;
      spur_q      <= 1'b0;
      isr_q       <= '0;
      int_out_q   <= 1'b0;
      irr_clear_q <= '0;
      vec_q       <= '0;
      vec_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      ptr_q       <= ptr_d;
      level_q     <= level_d;
      spur_q      <= spur_d;
      isr_q       <= isr_d;
      int_out_q   <= int_out_d;
      irr_clear_q <= irr_clear_d;
      vec_q       <= vec_d;
      vec_oe_q    <= vec_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inta_fall) state_d = ACK1; else if (qual) state_d = REQ;
      REQ:     if (inta_fall) state_d = ACK1; else if (!qual) state_d = IDLE;
      ACK1:    if (inta_fall) state_d = ACK2;
      ACK2:    if (inta_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    isr_d       = isr_q;
    ptr_d       = ptr_q;
    level_d     = level_q;
    spur_d      = spur_q;
    int_out_d   = 1'b0;
    irr_clear_d = '0;
    vec_d       = vec_q;
    vec_oe_d    = vec_oe_q;

    // EOI is applied first so an acknowledge in the same cycle sets its bit on top of it.
    if (eoi_cmd) begin
      if (eoi_specific) begin
        isr_d[eoi_level] = 1'b0;
      end else if (top_v) begin
        isr_d[top_lvl] = 1'b0;
        if (ROTATE) ptr_d = top_lvl;
      end
    end

    case (state_q)
      IDLE: begin
        int_out_d = qual & ~inta_fall;
        if (inta_fall) begin
          level_d = 3'd7;
          spur_d  = 1'b1;
        end
      end
      REQ: begin
        int_out_d = qual & ~inta_fall;
        if (inta_fall) begin
          if (qual) begin
            isr_d[win_lvl]       = 1'b1;
            irr_clear_d[win_lvl] = 1'b1;
            level_d              = win_lvl;
            spur_d               = 1'b0;
          end else begin
            level_d = 3'd7;
            spur_d  = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_fall) begin
          vec_d    = {vec_base, level_q};
          vec_oe_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          vec_oe_d = 1'b0;
          if (auto_eoi && !spur_q) begin
            isr_d[level_q] = 1'b0;
            if (ROTATE) ptr_d = level_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign int_out    = int_out_q;
  assign isr        = isr_q;
  assign irr_clear  = irr_clear_q;
  assign vector_out = vec_q;
  assign vector_oe  = vec_oe_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Self-checking bench for pic_int_sequencer: directed handshake scenarios plus randomized
// request/EOI traffic against a transaction-level priority model.
module tb_pic_int_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irr = '0, imr = '0;
  logic       inta_n = 1'b1, eoi_cmd = 1'b0, eoi_specific = 1'b0, auto_eoi = 1'b0;
  logic [2:0] eoi_level = '0;
  logic [4:0] vec_base = 5'h11;
  logic       int_out, vector_oe;
  logic [7:0] isr, irr_clear, vector_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_isr;
  int         m_ptr;

  always #5 clk = ~clk;

  pic_int_sequencer #(.NUM_IR(8), .VEC_BASE_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta_n(inta_n),
    .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .auto_eoi(auto_eoi), .vec_base(vec_base), .int_out(int_out), .isr(isr),
    .irr_clear(irr_clear), .vector_out(vector_out), .vector_oe(vector_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Priority order: level m_ptr+1 is served first, level m_ptr last.
  function automatic int m_best(input logic [7:0] v);
    for (int k = 1; k <= 8; k++) begin
      if (v[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic int m_prio(input int l);
    return (l - m_ptr + 7) % 8;
  endfunction

  function automatic int m_winner(input logic [7:0] r, input logic [7:0] m);
    int w, t;
    w = m_best(r & ~m);
    t = m_best(m_isr);
    if (w < 0) return -1;
    if (t >= 0 && m_prio(w) >= m_prio(t)) return -1;
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({int_out, isr, irr_clear, vector_out, vector_oe} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs got int=%b isr=%h clr=%h vec=%h oe=%b exp all zero",
               int_out, isr, irr_clear, vector_out, vector_oe);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    irr = 8'h04; imr = '0; auto_eoi = 1'b0;
    tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int_out got %b exp 1", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (isr !== 8'h04) begin errors++; $display("FAIL basic_isr got %h exp 04", isr); end
    checks++; if (irr_clear !== 8'h04) begin errors++; $display("FAIL basic_irr_clear got %h exp 04", irr_clear); end
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_drop got %b exp 0", int_out); end
    irr = '0; tick();
    checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL basic_clear_pulse got %h exp 00", irr_clear); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_oe !== 1'b1 || vector_out !== 8'h8A) begin
      errors++; $display("FAIL basic_vector got oe=%b vec=%h exp oe=1 vec=8a", vector_oe, vector_out); end
    tick();
    checks++; if (vector_oe !== 1'b1) begin errors++; $display("FAIL basic_oe_hold got %b exp 1", vector_oe); end
    inta_n = 1'b1; tick();
    checks++; if (vector_oe !== 1'b0 || isr !== 8'h04) begin
      errors++; $display("FAIL basic_end got oe=%b isr=%h exp oe=0 isr=04", vector_oe, isr); end
  endtask

  task automatic test_nesting();
    irr = 8'h10; tick(); tick();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_lower_blocked got %b exp 0", int_out); end
    irr = 8'h01; tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_higher_int got %b exp 1", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (irr_clear !== 8'h01) begin errors++; $display("FAIL nest_irr_clear got %h exp 01", irr_clear); end
    irr = '0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_out !== 8'h88) begin errors++; $display("FAIL nest_vector got %h exp 88", vector_out); end
    inta_n = 1'b1; tick();
    checks++; if (isr !== 8'h05) begin errors++; $display("FAIL nest_isr got %h exp 05", isr); end
  endtask

  task automatic test_eoi();
    eoi_cmd = 1'b1; eoi_specific = 1'b0; tick();
    eoi_cmd = 1'b0;
    checks++; if (isr !== 8'h04) begin errors++; $display("FAIL eoi_nonspecific got %h exp 04", isr); end
    eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2; tick();
    eoi_cmd = 1'b0;
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific got %h exp 00", isr); end
    eoi_cmd = 1'b1; eoi_specific = 1'b0; tick();
    eoi_cmd = 1'b0;
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL eoi_empty got %h exp 00", isr); end
  endtask

  task automatic test_aeoi();
    auto_eoi = 1'b1; irr = 8'h80; tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL aeoi_int got %b exp 1", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (isr !== 8'h80) begin errors++; $display("FAIL aeoi_isr_set got %h exp 80", isr); end
    irr = '0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_out !== 8'h8F) begin errors++; $display("FAIL aeoi_vector got %h exp 8f", vector_out); end
    inta_n = 1'b1; tick();
    checks++; if (isr !== 8'h00 || vector_oe !== 1'b0) begin
      errors++; $display("FAIL aeoi_clear got isr=%h oe=%b exp isr=00 oe=0", isr, vector_oe); end
    auto_eoi = 1'b0;
  endtask

  task automatic test_spurious();
    irr = 8'h08; tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL spur_int got %b exp 1", int_out); end
    irr = '0; tick();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL spur_withdraw got %b exp 0", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (isr !== 8'h00 || irr_clear !== 8'h00) begin
      errors++; $display("FAIL spur_ack1 got isr=%h clr=%h exp 00 00", isr, irr_clear); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_out !== 8'h8F || vector_oe !== 1'b1) begin
      errors++; $display("FAIL spur_vector got vec=%h oe=%b exp vec=8f oe=1", vector_out, vector_oe); end
    inta_n = 1'b1; tick();
    checks++; if (isr !== 8'h00 || vector_oe !== 1'b0) begin
      errors++; $display("FAIL spur_end got isr=%h oe=%b exp isr=00 oe=0", isr, vector_oe); end
  endtask

  task automatic test_eoi_ack_overlap();
    irr = 8'h04; tick();
    inta_n = 1'b0; tick();
    irr = '0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    irr = 8'h01; tick();
    inta_n = 1'b0; eoi_cmd = 1'b1; eoi_specific = 1'b0; tick();
    eoi_cmd = 1'b0;
    checks++; if (isr !== 8'h01 || irr_clear !== 8'h01) begin
      errors++; $display("FAIL overlap_isr got isr=%h clr=%h exp isr=01 clr=01", isr, irr_clear); end
    irr = '0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0; tick();
    eoi_cmd = 1'b0;
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL overlap_cleanup got %h exp 00", isr); end
  endtask

  task automatic test_reset_mid();
    irr = 8'h02; tick();
    inta_n = 1'b0; tick();
    irr = '0; inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_oe !== 1'b1) begin errors++; $display("FAIL rmid_setup_oe got %b exp 1", vector_oe); end
    rst_n = 1'b0; #1;
    checks++;
    if ({int_out, isr, irr_clear, vector_out, vector_oe} !== 26'd0) begin
      errors++;
      $display("FAIL rmid_async got int=%b isr=%h clr=%h vec=%h oe=%b exp all zero",
               int_out, isr, irr_clear, vector_out, vector_oe);
    end
    tick();
    rst_n = 1'b1; inta_n = 1'b1; tick(); tick();
    checks++;
    if ({int_out, isr, vector_oe} !== 10'd0) begin
      errors++; $display("FAIL rmid_after got int=%b isr=%h oe=%b exp 0", int_out, isr, vector_oe);
    end
  endtask

`ifdef PIC_ROTATE_EN
  task automatic test_rotate();
    irr = 8'h01; tick();
    inta_n = 1'b0; tick();
    irr = '0; inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    eoi_cmd = 1'b1; eoi_specific = 1'b0; tick();
    eoi_cmd = 1'b0;
    irr = 8'h81; tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL rot_int got %b exp 1", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (irr_clear !== 8'h80) begin errors++; $display("FAIL rot_winner got %h exp 80", irr_clear); end
    irr = 8'h01; inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++; if (vector_out !== 8'h8F) begin errors++; $display("FAIL rot_vector got %h exp 8f", vector_out); end
    inta_n = 1'b1; tick(); tick();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL rot_ir0_blocked got %b exp 0", int_out); end
    irr = '0; eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd7; tick();
    eoi_cmd = 1'b0; tick();
  endtask
`endif

  task automatic test_random();
    logic [7:0] r, m, oh, exp_v;
    logic [4:0] vb;
    logic       ae, sp;
    int         w, t, lvl;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    m_isr = '0;
    m_ptr = 7;
    for (int it = 0; it < 80; it++) begin
      vb = 5'($urandom); ae = 1'($urandom_range(0, 1));
      r  = 8'($urandom); m = 8'($urandom & $urandom);
      vec_base = vb; auto_eoi = ae;
      w = m_winner(r, m);
      irr = r; imr = m; tick();
      checks++; if (int_out !== (w >= 0)) begin
        errors++; $display("FAIL rnd_int it=%0d irr=%h imr=%h isr=%h got %b exp %b", it, r, m, m_isr, int_out, w >= 0); end
      if (w >= 0) begin
        oh = 8'h01 << w;
        inta_n = 1'b0; tick();
        checks++; if (isr !== (m_isr | oh) || irr_clear !== oh) begin
          errors++; $display("FAIL rnd_ack1 it=%0d got isr=%h clr=%h exp isr=%h clr=%h", it, isr, irr_clear, m_isr | oh, oh); end
        m_isr = m_isr | oh;
        irr = '0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        exp_v = {vb, 3'(w)};
        checks++; if (vector_out !== exp_v || vector_oe !== 1'b1) begin
          errors++; $display("FAIL rnd_vector it=%0d got vec=%h oe=%b exp vec=%h oe=1", it, vector_out, vector_oe, exp_v); end
        inta_n = 1'b1; tick();
        if (ae) begin
          m_isr = m_isr & ~oh;
`ifdef PIC_ROTATE_EN
          m_ptr = w;
`endif
        end
        checks++; if (isr !== m_isr || vector_oe !== 1'b0) begin
          errors++; $display("FAIL rnd_ack2 it=%0d got isr=%h oe=%b exp isr=%h oe=0", it, isr, vector_oe, m_isr); end
      end else begin
        irr = '0; tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        sp = 1'($urandom_range(0, 1)); lvl = $urandom_range(0, 7);
        eoi_cmd = 1'b1; eoi_specific = sp; eoi_level = 3'(lvl); tick();
        eoi_cmd = 1'b0;
        if (sp) begin
          m_isr[lvl] = 1'b0;
        end else begin
          t = m_best(m_isr);
          if (t >= 0) begin
            m_isr[t] = 1'b0;
`ifdef PIC_ROTATE_EN
            m_ptr = t;
`endif
          end
        end
        checks++; if (isr !== m_isr) begin
          errors++; $display("FAIL rnd_eoi it=%0d spec=%b lvl=%0d got %h exp %h", it, sp, lvl, isr, m_isr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_eoi();
    test_aeoi();
    test_spurious();
    test_eoi_ack_overlap();
    test_reset_mid();
`ifdef PIC_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
- Control and priority-resolution sequencer for the 8259 PIC.
- Takes masked interrupt requests and arbitrates the eight IR levels under fully-nested priority.
- Runs the two-pulse 8086 INTA handshake, sets and clears in-service bits, and drives the interrupt vector.
- Sits between the IRR/IMR registers and the data-bus buffer; owns the in-service state that the combinational ISR logic previously derived.

Parameters:
- NUM_IR, 8, number of interrupt levels (the design supports only 8; fixed for vector encoding).
- VEC_BASE_W, 5, width of the ICW2 vector base field (T7..T3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irr  input  8  pending interrupt requests (bit0 = IR0).
- imr  input  8  interrupt mask register; 1 = masked.
- inta_n  input  1  CPU interrupt acknowledge, active low, synchronous to clk.
- eoi_cmd  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  qualifies eoi_cmd: 1 = specific EOI, 0 = non-specific.
- eoi_level  input  3  level to clear on specific EOI.
- auto_eoi  input  1  ICW4 AEOI mode.
- vec_base  input  5  ICW2 T7..T3.
- int_out  output  1  interrupt request to the CPU.
- isr  output  8  in-service register.
- irr_clear  output  8  one-cycle one-hot pulse that clears the acknowledged IRR bit.
- vector_out  output  8  interrupt vector {vec_base, level}.
- vector_oe  output  1  data-bus drive enable for vector_out.

Behaviour:
- **Reset (async, rst_n=0):**
  - isr=0, int_out=0, irr_clear=0, vector_out=0, vector_oe=0.
  - state=IDLE, rotation pointer=7 (IR0 highest).
- **Priority:**
  - eligible = irr & ~imr.
  - Winner = highest-priority eligible bit, starting after the rotation pointer (IR0 first when no rotation).
  - A request counts only if its priority is strictly higher than the highest set isr bit.
- **INTA edge:** inta_fall = registered inta_n was 1 and current inta_n is 0.
- **IDLE:**
  - If a qualifying request exists, set int_out=1 on the next edge (1-cycle latency) and go to REQ.
- **REQ:**
  - If the request disappears before INTA, clear int_out the next cycle and return to IDLE.
  - On inta_fall, go to ACK1 and deassert int_out.
  - If a winner exists: set isr[winner], pulse irr_clear[winner] for one cycle, latch level=winner.
  - If no winner (request withdrawn): spurious case, latch level=7, no isr/irr_clear change.
- **ACK1:**
  - Wait for inta_n=1, then the next inta_fall, then go to ACK2.
  - On entering ACK2, vector_out={vec_base, level} and vector_oe=1.
- **ACK2:**
  - vector_oe is held while inta_n=0.
  - On inta_n rising: vector_oe=0; if auto_eoi=1 and not spurious, clear isr[level]; go to IDLE.
  - IDLE re-evaluates requests next cycle.
- **EOI (any state):**
  - Non-specific clears the highest-priority set isr bit.
  - Specific clears isr[eoi_level].
  - EOI when isr=0 is a no-op.
- **Simultaneous EOI and first inta_fall:** the EOI acts on isr before the new bit is set; both take effect in the same cycle.
- **inta_fall in IDLE** (no int_out): treated as spurious, level=7, proceed to ACK1.
- **Reset mid-handshake:** returns to IDLE with all outputs cleared; no partial vector is driven.

Optional Feature:
- Macro PIC_ROTATE_EN.
- Defined: a non-specific EOI or AEOI completion also sets the rotation pointer to the cleared level, so that level becomes lowest priority (automatic rotation).
- Undefined: pointer is fixed at 7 and fully-nested IR0-highest priority applies always.

Test Plan:
1. irr=0x04, imr=0 → int_out=1 one cycle later; two INTA pulses → isr=0x04, irr_clear=0x04 pulse, vector_out=vec_base<<3|2 with vector_oe during the second pulse.
2. isr=0x04 in service, irr=0x10 → int_out stays 0; irr=0x01 → int_out=1, second ack gives isr=0x05.
3. isr=0x05, non-specific EOI → isr=0x04; specific EOI level 2 → isr=0x00.
4. auto_eoi=1, irr=0x80 → after second INTA rises, isr=0x00, vector low bits = 7.
5. int_out raised for IR3, irr drops before first INTA → int_out=0; an INTA issued anyway gives vector level 7 and isr unchanged.
6. With PIC_ROTATE_EN: service IR0, non-specific EOI, then irr=0x81 → IR7 acknowledged before IR0.
